icb_buffer: RTL and testbench

- Parametrised ICB register/buffer stage between an upstream ICB master and a downstream ICB slave.
- Command and response channels are each decoupled by a synchronous FIFO.
- Address width, data width and FIFO depths are configurable.
- A limit on outstanding transactions throttles command issue.
- Used to cut timing paths and absorb back-pressure, e.g. in front of the ICB-to-APB bridge.

---
 rtl/icb_buffer.sv | 215 +++++++++++++++++++++
 tb/tb_icb_buffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : icb_buffer
// Brief    : ICB register/buffer stage. Command and response channels are
//            decoupled by synchronous FIFOs with registered outputs (no
//            fall-through). Command issue is throttled by a limit on
//            transactions sent downstream but not yet returned upstream.
//            Responses come back strictly in command order.
// Ports    : clk, rst (async, active-high)
//            s_icb_cmd_*  upstream command  (valid/ready/addr/read/wdata/wmask)
//            s_icb_rsp_*  upstream response (valid/ready/rdata/err)
//            m_icb_cmd_*  downstream command
//            m_icb_rsp_*  downstream response
//            stat_*       statistics outputs, present only with
//                         ICB_BUF_STATS_EN defined
// Options  : `define ICB_BUF_STATS_EN to add stat_cmd_cnt, stat_err_cnt and
//            stat_max_occ.
// Revision : 1.0 - initial release
// ============================================================================
module icb_buffer #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64,
    parameter int CMD_DEPTH       = 4,
    parameter int RSP_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int C_MASK_W       = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_icb_cmd_valid,
    output logic                          s_icb_cmd_ready,
    input  logic [ADDR_W-1:0]             s_icb_cmd_addr,
    input  logic                          s_icb_cmd_read,
    input  logic [DATA_W-1:0]             s_icb_cmd_wdata,
    input  logic [C_MASK_W-1:0]           s_icb_cmd_wmask,
    output logic                          s_icb_rsp_valid,
    input  logic                          s_icb_rsp_ready,
    output logic [DATA_W-1:0]             s_icb_rsp_rdata,
    output logic                          s_icb_rsp_err,
    output logic                          m_icb_cmd_valid,
    input  logic                          m_icb_cmd_ready,
    output logic [ADDR_W-1:0]             m_icb_cmd_addr,
    output logic                          m_icb_cmd_read,
    output logic [DATA_W-1:0]             m_icb_cmd_wdata,
    output logic [C_MASK_W-1:0]           m_icb_cmd_wmask,
    input  logic                          m_icb_rsp_valid,
    output logic                          m_icb_rsp_ready,
    input  logic [DATA_W-1:0]             m_icb_rsp_rdata,
    input  logic                          m_icb_rsp_err
`ifdef ICB_BUF_STATS_EN
    ,
    output logic [31:0]                   stat_cmd_cnt,
    output logic [31:0]                   stat_err_cnt,
    output logic [$clog2(CMD_DEPTH):0]    stat_max_occ
`endif
);

    localparam int C_CMD_AW = $clog2(CMD_DEPTH);
    localparam int C_RSP_AW = $clog2(RSP_DEPTH);
    localparam int C_OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int C_CMD_W  = ADDR_W + 1 + DATA_W + C_MASK_W;
    localparam int C_RSP_W  = DATA_W + 1;

    localparam logic [C_CMD_AW:0]  C_CMD_FULL = (C_CMD_AW + 1)'(CMD_DEPTH);
    localparam logic [C_RSP_AW:0]  C_RSP_FULL = (C_RSP_AW + 1)'(RSP_DEPTH);
    localparam logic [C_OUT_W-1:0] C_MAX_OUT  = C_OUT_W'(MAX_OUTSTANDING);

    // ------------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------------
    logic w_cmd_push;   // upstream command accepted
    logic w_cmd_pop;    // downstream command accepted
    logic w_rsp_push;   // downstream response accepted
    logic w_rsp_pop;    // upstream response accepted
    logic w_issue_ok;   // outstanding limit not reached

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [C_CMD_W-1:0]  r_cmd_mem [CMD_DEPTH];
    logic [C_CMD_AW-1:0] r_cmd_wptr;
    logic [C_CMD_AW-1:0] r_cmd_rptr;
    logic [C_CMD_AW:0]   r_cmd_cnt;

    // Ready is forced low during reset, since the count is already zero
    // there and would otherwise report space.
    assign s_icb_cmd_ready = !rst && (r_cmd_cnt != C_CMD_FULL);
    assign m_icb_cmd_valid = (r_cmd_cnt != '0) && w_issue_ok;
    assign w_cmd_push      = s_icb_cmd_valid && s_icb_cmd_ready;
    assign w_cmd_pop       = m_icb_cmd_valid && m_icb_cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                r_cmd_mem[i] <= '0;
            end
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
            r_cmd_cnt  <= '0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_mem[r_cmd_wptr] <= {s_icb_cmd_addr, s_icb_cmd_read,
                                          s_icb_cmd_wdata, s_icb_cmd_wmask};
                r_cmd_wptr <= r_cmd_wptr + 1'b1;
            end
            if (w_cmd_pop) begin
                r_cmd_rptr <= r_cmd_rptr + 1'b1;
            end
            if (w_cmd_push && !w_cmd_pop) begin
                r_cmd_cnt <= r_cmd_cnt + 1'b1;
            end else if (!w_cmd_push && w_cmd_pop) begin
                r_cmd_cnt <= r_cmd_cnt - 1'b1;
            end
        end
    end

    // Storage is reset, so the head entry reads as zero after reset.
    assign {m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask} =
        r_cmd_mem[r_cmd_rptr];

    // ------------------------------------------------------------------------
    // Outstanding counter: a transaction is counted from its downstream
    // command handshake until its upstream response handshake. It only
    // increments on an issue, so the gate cannot close under a valid that
    // is still waiting for ready.
    // ------------------------------------------------------------------------
    logic [C_OUT_W-1:0] r_outst;

    assign w_issue_ok = (r_outst < C_MAX_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst <= '0;
        end else if (w_cmd_pop && !w_rsp_pop) begin
            r_outst <= r_outst + 1'b1;
        end else if (!w_cmd_pop && w_rsp_pop) begin
            r_outst <= r_outst - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------------
    logic [C_RSP_W-1:0]  r_rsp_mem [RSP_DEPTH];
    logic [C_RSP_AW-1:0] r_rsp_wptr;
    logic [C_RSP_AW-1:0] r_rsp_rptr;
    logic [C_RSP_AW:0]   r_rsp_cnt;

    assign m_icb_rsp_ready = !rst && (r_rsp_cnt != C_RSP_FULL);
    assign s_icb_rsp_valid = (r_rsp_cnt != '0);
    assign w_rsp_push      = m_icb_rsp_valid && m_icb_rsp_ready;
    assign w_rsp_pop       = s_icb_rsp_valid && s_icb_rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_rsp_mem[i] <= '0;
            end
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
            r_rsp_cnt  <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_mem[r_rsp_wptr] <= {m_icb_rsp_rdata, m_icb_rsp_err};
                r_rsp_wptr <= r_rsp_wptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rptr <= r_rsp_rptr + 1'b1;
            end
            if (w_rsp_push && !w_rsp_pop) begin
                r_rsp_cnt <= r_rsp_cnt + 1'b1;
            end else if (!w_rsp_push && w_rsp_pop) begin
                r_rsp_cnt <= r_rsp_cnt - 1'b1;
            end
        end
    end

    assign {s_icb_rsp_rdata, s_icb_rsp_err} = r_rsp_mem[r_rsp_rptr];

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef ICB_BUF_STATS_EN
    logic [31:0]       r_stat_cmd;
    logic [31:0]       r_stat_err;
    logic [C_CMD_AW:0] r_stat_max;

    // Event counters saturate at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_cmd <= '0;
            r_stat_err <= '0;
            r_stat_max <= '0;
        end else begin
            if (w_cmd_push && (r_stat_cmd != '1)) begin
                r_stat_cmd <= r_stat_cmd + 32'd1;
            end
            if (w_rsp_pop && s_icb_rsp_err && (r_stat_err != '1)) begin
                r_stat_err <= r_stat_err + 32'd1;
            end
            if (r_cmd_cnt > r_stat_max) begin
                r_stat_max <= r_cmd_cnt;
            end
        end
    end

    assign stat_cmd_cnt = r_stat_cmd;
    assign stat_err_cnt = r_stat_err;
    assign stat_max_occ = r_stat_max;
`else
    // Statistics disabled: no counters or ports are built.
`endif

endmodule
`default_nettype wire

// File: tb/tb_icb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_icb_buffer
// Brief    : Self-checking bench for icb_buffer. A queue-based model of the
//            buffer (command queue, response queue, in-flight count) predicts
//            every handshake-visible output each cycle. Directed scenarios
//            are followed by a randomized phase. Configuration: CMD_DEPTH=4,
//            RSP_DEPTH=2, MAX_OUTSTANDING=2 so the outstanding limit and the
//            response-FIFO full boundary can both be reached.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icb_buffer;

    localparam int AW      = 32;
    localparam int DW      = 64;
    localparam int MW      = DW / 8;
    localparam int CD      = 4;
    localparam int RD      = 2;
    localparam int MO      = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } cmd_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_icb_cmd_valid;
    logic          s_icb_cmd_ready;
    logic [AW-1:0] s_icb_cmd_addr;
    logic          s_icb_cmd_read;
    logic [DW-1:0] s_icb_cmd_wdata;
    logic [MW-1:0] s_icb_cmd_wmask;
    logic          s_icb_rsp_valid;
    logic          s_icb_rsp_ready;
    logic [DW-1:0] s_icb_rsp_rdata;
    logic          s_icb_rsp_err;
    logic          m_icb_cmd_valid;
    logic          m_icb_cmd_ready;
    logic [AW-1:0] m_icb_cmd_addr;
    logic          m_icb_cmd_read;
    logic [DW-1:0] m_icb_cmd_wdata;
    logic [MW-1:0] m_icb_cmd_wmask;
    logic          m_icb_rsp_valid;
    logic          m_icb_rsp_ready;
    logic [DW-1:0] m_icb_rsp_rdata;
    logic          m_icb_rsp_err;
`ifdef ICB_BUF_STATS_EN
    logic [31:0]           stat_cmd_cnt;
    logic [31:0]           stat_err_cnt;
    logic [$clog2(CD):0]   stat_max_occ;
`endif

    always #5 clk = ~clk;

    icb_buffer #(
        .ADDR_W          (AW),
        .DATA_W          (DW),
        .CMD_DEPTH       (CD),
        .RSP_DEPTH       (RD),
        .MAX_OUTSTANDING (MO)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .s_icb_cmd_valid (s_icb_cmd_valid),
        .s_icb_cmd_ready (s_icb_cmd_ready),
        .s_icb_cmd_addr  (s_icb_cmd_addr),
        .s_icb_cmd_read  (s_icb_cmd_read),
        .s_icb_cmd_wdata (s_icb_cmd_wdata),
        .s_icb_cmd_wmask (s_icb_cmd_wmask),
        .s_icb_rsp_valid (s_icb_rsp_valid),
        .s_icb_rsp_ready (s_icb_rsp_ready),
        .s_icb_rsp_rdata (s_icb_rsp_rdata),
        .s_icb_rsp_err   (s_icb_rsp_err),
        .m_icb_cmd_valid (m_icb_cmd_valid),
        .m_icb_cmd_ready (m_icb_cmd_ready),
        .m_icb_cmd_addr  (m_icb_cmd_addr),
        .m_icb_cmd_read  (m_icb_cmd_read),
        .m_icb_cmd_wdata (m_icb_cmd_wdata),
        .m_icb_cmd_wmask (m_icb_cmd_wmask),
        .m_icb_rsp_valid (m_icb_rsp_valid),
        .m_icb_rsp_ready (m_icb_rsp_ready),
        .m_icb_rsp_rdata (m_icb_rsp_rdata),
        .m_icb_rsp_err   (m_icb_rsp_err)
`ifdef ICB_BUF_STATS_EN
        ,
        .stat_cmd_cnt    (stat_cmd_cnt),
        .stat_err_cnt    (stat_err_cnt),
        .stat_max_occ    (stat_max_occ)
`endif
    );

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    cmd_t cmdq[$];      // accepted upstream, not yet issued downstream
    rsp_t rspq[$];      // returned downstream, not yet taken upstream
    int   outst;        // issued downstream, not yet taken upstream
    int   pend_n;       // issued downstream, downstream has not answered
    int   n_issued;
    int   m_cmds;
    int   m_errs;
    int   m_maxocc;

    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        cmdq.delete();
        rspq.delete();
        outst    = 0;
        pend_n   = 0;
        m_cmds   = 0;
        m_errs   = 0;
        m_maxocc = 0;
    endtask

    // One clock cycle, entered and left at a falling edge. Outputs are
    // compared with the model, the handshakes seen now take effect at the
    // rising edge, and accepted source valids are dropped just after it.
    task automatic step();
        bit   exp_v, hs_sc, hs_mc, hs_mr, hs_sr;
        cmd_t c;
        rsp_t r;
        check("s_cmd_ready", s_icb_cmd_ready, cmdq.size() < CD);
        exp_v = (cmdq.size() != 0) && (outst < MO);
        check("m_cmd_valid", m_icb_cmd_valid, exp_v);
        if (exp_v)
            check("m_cmd_payload", {m_icb_cmd_addr, m_icb_cmd_read,
                                    m_icb_cmd_wdata, m_icb_cmd_wmask}, cmdq[0]);
        check("s_rsp_valid", s_icb_rsp_valid, rspq.size() != 0);
        if (rspq.size() != 0)
            check("s_rsp_payload", {s_icb_rsp_rdata, s_icb_rsp_err}, rspq[0]);
        check("m_rsp_ready", m_icb_rsp_ready, rspq.size() < RD);

        hs_sc = s_icb_cmd_valid && s_icb_cmd_ready;
        hs_mc = m_icb_cmd_valid && m_icb_cmd_ready;
        hs_mr = m_icb_rsp_valid && m_icb_rsp_ready;
        hs_sr = s_icb_rsp_valid && s_icb_rsp_ready;
        c = '{addr: s_icb_cmd_addr, read: s_icb_cmd_read,
              wdata: s_icb_cmd_wdata, wmask: s_icb_cmd_wmask};
        r = '{rdata: m_icb_rsp_rdata, err: m_icb_rsp_err};

        @(posedge clk);
        #1;
        if (hs_mc && cmdq.size() != 0) begin
            void'(cmdq.pop_front());
            outst++;
            pend_n++;
            n_issued++;
        end
        if (hs_sc) begin
            cmdq.push_back(c);
            m_cmds++;
            s_icb_cmd_valid = 1'b0;
        end
        if (hs_sr && rspq.size() != 0) begin
            if (rspq[0].err) m_errs++;
            void'(rspq.pop_front());
            outst--;
        end
        if (hs_mr) begin
            rspq.push_back(r);
            pend_n--;
            m_icb_rsp_valid = 1'b0;
        end
        if (cmdq.size() > m_maxocc) m_maxocc = cmdq.size();
        @(negedge clk);
    endtask

    task automatic send_cmd(input bit rd, input logic [AW-1:0] addr);
        int n = 0;
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_read  = rd;
        s_icb_cmd_addr  = addr;
        s_icb_cmd_wdata = {$urandom, $urandom};
        s_icb_cmd_wmask = MW'($urandom_range(0, 255));
        while (s_icb_cmd_valid && n < 50) begin
            step();
            n++;
        end
        check("send_accept", s_icb_cmd_valid, 1'b0);
    endtask

    task automatic down_rsp(input logic err);
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_rdata = {$urandom, $urandom};
        m_icb_rsp_err   = err;
        step();
    endtask

    task automatic drain();
        int n = 0;
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b1;
        while ((cmdq.size() != 0 || rspq.size() != 0 || pend_n != 0 ||
                s_icb_cmd_valid || m_icb_rsp_valid) && n < 200) begin
            if (!m_icb_rsp_valid && pend_n > 0) begin
                m_icb_rsp_valid = 1'b1;
                m_icb_rsp_rdata = {$urandom, $urandom};
                m_icb_rsp_err   = 1'($urandom_range(0, 1));
            end
            step();
            n++;
        end
        check("drain_done", n < 200, 1'b1);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        s_icb_cmd_valid = 1'b0; s_icb_cmd_addr = '0; s_icb_cmd_read = 1'b0;
        s_icb_cmd_wdata = '0;   s_icb_cmd_wmask = '0; s_icb_rsp_ready = 1'b0;
        m_icb_cmd_ready = 1'b0; m_icb_rsp_valid = 1'b0;
        m_icb_rsp_rdata = '0;   m_icb_rsp_err = 1'b0;
        model_clear();
        n_issued = 0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_s_cmd_ready", s_icb_cmd_ready, 1'b0);
        check("rst_m_rsp_ready", m_icb_rsp_ready, 1'b0);
        check("rst_m_cmd_valid", m_icb_cmd_valid, 1'b0);
        check("rst_s_rsp_valid", s_icb_rsp_valid, 1'b0);
        check("rst_m_cmd_addr",  m_icb_cmd_addr, '0);
        check("rst_s_rsp_rdata", s_icb_rsp_rdata, '0);
`ifdef ICB_BUF_STATS_EN
        check("rst_stat_cmd", stat_cmd_cnt, '0);
        check("rst_stat_max", stat_max_occ, '0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single read with a fixed downstream response
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b1;
        send_cmd(1'b1, 32'h100);
        check("rd_issue_lat", m_icb_cmd_valid, 1'b1);
        step();
        m_icb_rsp_valid = 1'b1;
        m_icb_rsp_rdata = 64'hDEADBEEF_CAFEF00D;
        m_icb_rsp_err   = 1'b0;
        check("rd_rsp_not_yet", s_icb_rsp_valid, 1'b0);
        step();
        check("rd_rsp_valid", s_icb_rsp_valid, 1'b1);
        check("rd_rsp_rdata", s_icb_rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        check("rd_rsp_err",   s_icb_rsp_err, 1'b0);
        step();
        check("rd_rsp_done",  s_icb_rsp_valid, 1'b0);

        // Command FIFO fills under downstream back-pressure
        m_icb_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_cmd(1'b0, AW'(i * 8));
        check("cmd_full", s_icb_cmd_ready, 1'b0);
        s_icb_cmd_valid = 1'b1;
        s_icb_cmd_read  = 1'b0;
        s_icb_cmd_addr  = 32'h20;
        step();
        step();
        check("cmd_full_hold", s_icb_cmd_valid, 1'b1);
        drain();

        // Outstanding limit
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b0;
        base = n_issued;
        for (int i = 0; i < 4; i++) send_cmd(1'b1, AW'(32'h200 + i * 8));
        repeat (4) step();
        check("outst_issued", n_issued - base, 2);
        check("gate_closed", m_icb_cmd_valid, 1'b0);
        down_rsp(1'b0);
        check("gate_hold", m_icb_cmd_valid, 1'b0);
        s_icb_rsp_ready = 1'b1;
        step();
        check("gate_reopen", m_icb_cmd_valid, 1'b1);
        drain();

        // Response FIFO full; err order 0,1,0,1
        for (int k = 0; k < 2; k++) begin
            s_icb_rsp_ready = 1'b0;
            m_icb_cmd_ready = 1'b1;
            send_cmd(1'b1, AW'(32'h300 + k * 16));
            send_cmd(1'b1, AW'(32'h308 + k * 16));
            step();
            down_rsp(1'b0);
            down_rsp(1'b1);
            check("rsp_full", m_icb_rsp_ready, 1'b0);
            check("err_order0", s_icb_rsp_err, 1'b0);
            s_icb_rsp_ready = 1'b1;
            step();
            check("err_order1", s_icb_rsp_err, 1'b1);
            step();
        end
        drain();

        // Reset in the middle of traffic: 3 queued, 2 outstanding
        m_icb_cmd_ready = 1'b1;
        s_icb_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_cmd(1'b1, AW'(32'h400 + i * 8));
        check("pre_rst_queued", cmdq.size(), 3);
        rst = 1'b1;
        #1;
        check("mid_rst_m_cmd_valid", m_icb_cmd_valid, 1'b0);
        check("mid_rst_s_rsp_valid", s_icb_rsp_valid, 1'b0);
        check("mid_rst_s_cmd_ready", s_icb_cmd_ready, 1'b0);
        check("mid_rst_m_rsp_ready", m_icb_rsp_ready, 1'b0);
        check("mid_rst_m_cmd_addr",  m_icb_cmd_addr, '0);
        model_clear();
        s_icb_cmd_valid = 1'b0;
        m_icb_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s_icb_rsp_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!s_icb_cmd_valid && $urandom_range(0, 2) != 0) begin
                s_icb_cmd_valid = 1'b1;
                s_icb_cmd_addr  = $urandom;
                s_icb_cmd_read  = 1'($urandom_range(0, 1));
                s_icb_cmd_wdata = {$urandom, $urandom};
                s_icb_cmd_wmask = MW'($urandom_range(0, 255));
            end
            m_icb_cmd_ready = ($urandom_range(0, 3) != 0);
            s_icb_rsp_ready = ($urandom_range(0, 2) != 0);
            if (!m_icb_rsp_valid && pend_n > 0 && $urandom_range(0, 1) != 0) begin
                m_icb_rsp_valid = 1'b1;
                m_icb_rsp_rdata = {$urandom, $urandom};
                m_icb_rsp_err   = 1'($urandom_range(0, 3) == 0);
            end
            step();
        end
        drain();
        step();

`ifdef ICB_BUF_STATS_EN
        check("stat_cmd_cnt", stat_cmd_cnt, m_cmds);
        check("stat_err_cnt", stat_err_cnt, m_errs);
        check("stat_max_occ", stat_max_occ, m_maxocc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
